apb_master_arbiter: RTL and testbench

Shares one APB master port between NREQ on-chip requesters and sequences each transfer through the APB SETUP and ACCESS phases toward the slave memory. Arbitration is round-robin. A wait-state timeout keeps a stalled slave from hanging the bus. The block sits between the requesting agents and the PAddr/PWData/PWrite/PSel/PEnable bus that the memory model decodes.

---
 rtl/apb_master_arbiter.sv | 170 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port between NREQ requesters,
// sequencing SETUP/ACCESS phases and aborting transfers that stall too long.
module apb_master_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   ack,
   output logic              err,
   output logic [DW-1:0]     rdata,
   output logic [AW-1:0]     PAddr,
   output logic [DW-1:0]     PWData,
   output logic              PWrite,
   output logic              PSel,
   output logic              PEnable,
   input  logic              PReady,
   input  logic [DW-1:0]     PRData,
   output logic [1:0]        dbg_state
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   last_q, last_d;
   logic [LW-1:0]   gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [AW-1:0]   paddr_q, paddr_d;
   logic [DW-1:0]   pwdata_q, pwdata_d;
   logic            pwrite_q, pwrite_d;
   logic            psel_q, psel_d;
   logic            penable_q, penable_d;

   logic [NREQ-1:0] eligible;
   logic            found;
   logic [LW-1:0]   pick;

   // The requester being acked this cycle is masked so it cannot win twice in a row
   // on a stale req that it has not yet had the chance to drop.
   always_comb begin
      eligible = req & ~ack_q;
      found    = 1'b0;
      pick     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && eligible[(int'(last_q) + k) % NREQ]) begin
            found = 1'b1;
            pick  = LW'((int'(last_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;

      case (state_q)
         S_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (found) begin
               gnt_d     = pick;
               last_d    = pick;
               paddr_d   = req_addr[int'(pick)*AW +: AW];
               pwdata_d  = req_wdata[int'(pick)*DW +: DW];
               pwrite_d  = req_write[pick];
               psel_d    = 1'b1;
               cnt_d     = '0;
               state_d   = S_SETUP;
            end
         end

         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end

         S_ACCESS: begin
            if (PReady) begin
               ack_d     = NREQ'(1) << gnt_q;
               if (!pwrite_q) rdata_d = PRData;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = S_IDLE;
            end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
               // Abort: report the error but keep the last good read data.
               ack_d     = NREQ'(1) << gnt_q;
               err_d     = 1'b1;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= S_IDLE;
         last_q    <= LW'(NREQ - 1);
         gnt_q     <= '0;
         cnt_q     <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
      end
   end

   assign ack       = ack_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign PAddr     = paddr_q;
   assign PWData    = pwdata_q;
   assign PWrite    = pwrite_q;
   assign PSel      = psel_q;
   assign PEnable   = penable_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: APB slave/memory model, cycle-accurate phase checks
// and an ack scoreboard fed with expected {grant, err, is_read, rdata} entries.
module tb_apb_master_arbiter;

   localparam int NREQ    = 4;
   localparam int AW      = 16;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;
   localparam int EW      = 3 + 1 + 1 + DW;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    ack;
   logic               err;
   logic [DW-1:0]      rdata;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic               pwrite;
   logic               psel;
   logic               penable;
   logic               pready;
   logic [DW-1:0]      prdata;
   logic [1:0]         dbg_state;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   // slave model
   logic [DW-1:0] mem [0:255];
   int            wait_cfg = 0;
   logic          hang = 1'b0;
   int            acc_cnt = 0;
   int            wr_count = 0;

   always #5 clk = ~clk;

   apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .Rst(rst_n), .req(req), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .PAddr(paddr),
      .PWData(pwdata), .PWrite(pwrite), .PSel(psel), .PEnable(penable),
      .PReady(pready), .PRData(prdata), .dbg_state(dbg_state)
   );

   assign pready = psel & penable & (acc_cnt >= wait_cfg) & ~hang;
   assign prdata = mem[paddr[7:0]];

   always @(posedge clk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (psel && penable && pready && pwrite) begin
         mem[paddr[7:0]] <= pwdata;
         wr_count <= wr_count + 1;
      end
   end

   // scoreboard monitor
   logic [EW-1:0]   mon_e;
   logic [NREQ-1:0] exp_ack;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if (err === 1'b1 && ack === '0) begin
            errors++;
            $display("FAIL err_without_ack err=%b ack=%b required err=0", err, ack);
         end
         if (ack !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_ack ack=%b required none", ack);
            end else begin
               mon_e   = exp_q.pop_front();
               exp_ack = 4'b0001 << mon_e[EW-1 -: 3];
               if (ack !== exp_ack) begin
                  errors++;
                  $display("FAIL sb_ack got=%b required=%b", ack, exp_ack);
               end
               checks++;
               if (err !== mon_e[DW+1]) begin
                  errors++;
                  $display("FAIL sb_err got=%b required=%b", err, mon_e[DW+1]);
               end
               if (mon_e[DW]) begin
                  checks++;
                  if (rdata !== mon_e[DW-1:0]) begin
                     errors++;
                     $display("FAIL sb_rdata got=%h required=%h", rdata, mon_e[DW-1:0]);
                  end
               end
            end
         end
      end
   end

   task automatic push_exp(input int idx, input logic e, input logic rd, input logic [DW-1:0] d);
      logic [2:0] i3;
      i3 = idx[2:0];
      exp_q.push_back({i3, e, rd, d});
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req[i]                = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (psel !== 1'b0)    begin errors++; $display("FAIL rst_psel got=%b required=0", psel); end
      checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable got=%b required=0", penable); end
      checks++; if (pwrite !== 1'b0)  begin errors++; $display("FAIL rst_pwrite got=%b required=0", pwrite); end
      checks++; if (ack !== '0)       begin errors++; $display("FAIL rst_ack got=%b required=0", ack); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL rst_err got=%b required=0", err); end
      checks++; if (paddr !== '0)     begin errors++; $display("FAIL rst_paddr got=%h required=0", paddr); end
      checks++; if (pwdata !== '0)    begin errors++; $display("FAIL rst_pwdata got=%h required=0", pwdata); end
      checks++; if (rdata !== '0)     begin errors++; $display("FAIL rst_rdata got=%h required=0", rdata); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d required=0", dbg_state); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      do_reset();
      wait_cfg = 0;
      set_req(0, 1'b1, 16'h0050, 32'h0000_0050);
      push_exp(0, 1'b0, 1'b0, '0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (psel !== (c == 1 || c == 2)) begin
            errors++; $display("FAIL sw_psel cycle=%0d got=%b", c, psel);
         end
         checks++;
         if (penable !== (c == 2)) begin
            errors++; $display("FAIL sw_penable cycle=%0d got=%b", c, penable);
         end
         if (c == 1) begin
            checks++;
            if (paddr !== 16'h0050 || pwdata !== 32'h50 || pwrite !== 1'b1) begin
               errors++; $display("FAIL sw_bus addr=%h data=%h wr=%b required 0050/50/1", paddr, pwdata, pwrite);
            end
         end
         if (c == 3) begin
            checks++;
            if (ack !== 4'b0001 || err !== 1'b0) begin
               errors++; $display("FAIL sw_ack got=%b err=%b required 0001/0", ack, err);
            end
            req[0] = 1'b0;
         end
      end
      checks++;
      if (mem[8'h50] !== 32'h0000_0050) begin
         errors++; $display("FAIL sw_mem got=%h required=00000050", mem[8'h50]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      wait_cfg = 0;
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 1'b1, AW'(16'h10 + i), DW'(32'hA0 + i));
         push_exp(i, 1'b0, 1'b0, '0);
      end
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         checks++;
         if (psel !== (c % 3 != 0 && c < 13)) begin
            errors++; $display("FAIL b2b_psel cycle=%0d got=%b", c, psel);
         end
         checks++;
         if (ack !== ((c % 3 == 0 && c <= 12) ? (4'b0001 << (c / 3 - 1)) : 4'b0000)) begin
            errors++; $display("FAIL b2b_ack cycle=%0d got=%b", c, ack);
         end
         if (c % 3 == 1 && c < 13) begin
            checks++;
            if (paddr !== AW'(16'h10 + (c - 1) / 3)) begin
               errors++; $display("FAIL b2b_grant cycle=%0d addr=%h required=%h", c, paddr, 16'h10 + (c - 1) / 3);
            end
         end
         req = req & ~ack;
      end
   endtask

   task automatic test_read_wait();
      do_reset();
      wait_cfg = 2;
      set_req(2, 1'b0, 16'h0050, 32'h0);
      push_exp(2, 1'b0, 1'b1, 32'h0000_0050);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (penable !== (c >= 2 && c <= 4)) begin
            errors++; $display("FAIL rd_penable cycle=%0d got=%b", c, penable);
         end
         checks++;
         if (ack !== ((c == 5) ? 4'b0100 : 4'b0000)) begin
            errors++; $display("FAIL rd_ack cycle=%0d got=%b", c, ack);
         end
         if (c == 5) begin
            checks++;
            if (rdata !== 32'h0000_0050 || err !== 1'b0) begin
               errors++; $display("FAIL rd_data got=%h err=%b required 00000050/0", rdata, err);
            end
            req[2] = 1'b0;
         end
      end
      wait_cfg = 0;
   endtask

   task automatic test_timeout();
      int wr_before;
      wr_before = wr_count;
      hang = 1'b1;
      set_req(1, 1'b1, 16'h0060, 32'hDEAD_BEEF);
      push_exp(1, 1'b1, 1'b0, '0);
      for (int c = 1; c <= TIMEOUT + 3; c++) begin
         @(negedge clk);
         checks++;
         if (psel !== (c <= TIMEOUT + 2) || penable !== (c >= 2 && c <= TIMEOUT + 2)) begin
            errors++; $display("FAIL to_phase cycle=%0d psel=%b penable=%b", c, psel, penable);
         end
         checks++;
         if (ack !== ((c == TIMEOUT + 3) ? 4'b0010 : 4'b0000)) begin
            errors++; $display("FAIL to_ack cycle=%0d got=%b", c, ack);
         end
         if (c == TIMEOUT + 3) begin
            checks++;
            if (err !== 1'b1 || rdata !== 32'h0000_0050) begin
               errors++; $display("FAIL to_err err=%b rdata=%h required 1/00000050", err, rdata);
            end
            req[1] = 1'b0;
         end
      end
      checks++;
      if (wr_count !== wr_before) begin
         errors++; $display("FAIL to_nowrite writes=%0d required=%0d", wr_count, wr_before);
      end
      hang = 1'b0;
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset();
      set_req(1, 1'b1, 16'h0070, 32'h77);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (penable !== 1'b1) begin errors++; $display("FAIL rm_access got=%b required=1", penable); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         errors++; $display("FAIL rm_drop psel=%b penable=%b required 0/0", psel, penable);
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (ack !== '0) begin errors++; $display("FAIL rm_noack got=%b required=0", ack); end
      rst_n = 1'b1;
      set_req(3, 1'b1, 16'h0033, 32'h33);
      set_req(0, 1'b1, 16'h0030, 32'h30);
      push_exp(0, 1'b0, 1'b0, '0);
      push_exp(3, 1'b0, 1'b0, '0);
      c = 0;
      while ((req != '0 || exp_q.size() != 0) && c < 20) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            checks++;
            if (psel !== 1'b1 || paddr !== 16'h0030) begin
               errors++; $display("FAIL rm_first psel=%b addr=%h required 1/0030", psel, paddr);
            end
         end
         req = req & ~ack;
      end
      checks++;
      if (exp_q.size() != 0 || req != '0) begin
         errors++; $display("FAIL rm_complete pending=%0d req=%b required 0/0000", exp_q.size(), req);
      end
   endtask

   task automatic test_fairness();
      int n_ack;
      int last_c;
      do_reset();
      set_req(0, 1'b1, 16'h0080, 32'h80);
      set_req(2, 1'b1, 16'h0082, 32'h82);
      for (int i = 0; i < 8; i++) push_exp((i % 2 == 0) ? 0 : 2, 1'b0, 1'b0, '0);
      n_ack  = 0;
      last_c = 0;
      for (int c = 1; c <= 40 && n_ack < 8; c++) begin
         @(negedge clk);
         if (ack != '0) begin
            n_ack++;
            if (n_ack > 1) begin
               checks++;
               if (c - last_c != 3) begin
                  errors++; $display("FAIL fair_gap cycle=%0d gap=%0d required=3", c, c - last_c);
               end
            end
            last_c = c;
            if (n_ack == 8) req = '0;
         end
      end
      checks++;
      if (n_ack != 8) begin
         errors++; $display("FAIL fair_count acks=%0d required=8", n_ack);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_wait();
      test_timeout();
      test_reset_mid();
      test_fairness();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
